// File: rtl/tx_block_ctrl.sv
// Block transmit controller: captures a NUM_BITS block, loads the downstream shifter and
// counts line strobes until done. Optional prefetch spare register: TX_BLOCK_CTRL_PREFETCH_EN.
module tx_block_ctrl #(
  parameter int NUM_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  input  logic                falling_edge_found,
  input  logic                abort,
  output logic [NUM_BITS-1:0] tx_data,
  output logic                load_data,
  output logic                tx_enable,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [NUM_BITS-1:0] hold, hold_nxt;
  logic                xfer;

`ifdef TX_BLOCK_CTRL_PREFETCH_EN
  logic                spare_full, spare_full_nxt;
  logic [NUM_BITS-1:0] spare, spare_nxt;

  // The spare accepts a follow-on block while the current one is loading or shifting.
  assign in_ready = ~rst & ((state == IDLE) |
                            (((state == LOAD) | (state == SHIFT)) & ~spare_full));
`else
  assign in_ready = ~rst & (state == IDLE);
`endif

  assign xfer      = in_valid & in_ready;
  assign tx_data   = hold;
  assign load_data = (state == LOAD);
  assign tx_enable = (state == SHIFT);
  assign tx_busy   = (state != IDLE);
  assign tx_done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
`ifdef TX_BLOCK_CTRL_PREFETCH_EN
    spare_nxt      = spare;
    spare_full_nxt = spare_full;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          hold_nxt  = in_data;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (falling_edge_found) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef TX_BLOCK_CTRL_PREFETCH_EN
        if (spare_full) begin
          hold_nxt       = spare;
          spare_full_nxt = 1'b0;
          state_nxt      = LOAD;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
`ifdef TX_BLOCK_CTRL_PREFETCH_EN
    // A block handed over in the same cycle as abort is discarded along with the spare.
    if ((state == LOAD) || (state == SHIFT)) begin
      if (abort) begin
        spare_full_nxt = 1'b0;
      end else if (xfer) begin
        spare_nxt      = in_data;
        spare_full_nxt = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
    end
  end

`ifdef TX_BLOCK_CTRL_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spare      <= '0;
      spare_full <= 1'b0;
    end else begin
      spare      <= spare_nxt;
      spare_full <= spare_full_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tx_block_ctrl.sv
// Self-checking bench for tx_block_ctrl: randomized blocks, strobe gaps, aborts and resets
// checked against a phase-level model of the transmit sequence.
module tb_tx_block_ctrl;
  localparam int NB = 128;
`ifdef TX_BLOCK_CTRL_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  // Expected {in_ready, load_data, tx_enable, tx_busy, tx_done} per phase.
  localparam logic [4:0] E_RST   = 5'b00000;
  localparam logic [4:0] E_IDLE  = 5'b10000;
  localparam logic [4:0] E_LOAD  = {PF, 4'b1010};
  localparam logic [4:0] E_SHIFT = {PF, 4'b0110};
  localparam logic [4:0] E_FULL  = 5'b00110;
  localparam logic [4:0] E_DONE  = 5'b00011;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [NB-1:0] in_data = '0;
  logic          in_ready;
  logic          falling_edge_found = 1'b0;
  logic          abort = 1'b0;
  logic [NB-1:0] tx_data;
  logic          load_data, tx_enable, tx_busy, tx_done;
  logic [4:0]    obs;

  int checks = 0;
  int errors = 0;

  tx_block_ctrl #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .falling_edge_found(falling_edge_found), .abort(abort), .tx_data(tx_data),
    .load_data(load_data), .tx_enable(tx_enable), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  assign obs = {in_ready, load_data, tx_enable, tx_busy, tx_done};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] rand_block();
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // kill_kind: 0 none, 1 abort with strobe kill_at, 2 reset just after strobe kill_at
  task automatic run_block(input logic [NB-1:0] data, input int gap_min, input int gap_max,
                           input int kill_at, input int kill_kind);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (in_ready !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b exp=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    cyc();
    in_valid = 1'b0;
    in_data  = rand_block();
    checks++;
    if (obs !== E_LOAD || tx_data !== data) begin
      errors++;
      $display("FAIL load obs=%b exp=%b tx_data=%h exp=%h", obs, E_LOAD, tx_data, data);
    end
    falling_edge_found = 1'($urandom_range(0, 1));
    cyc();
    falling_edge_found = 1'b0;
    checks++;
    if (obs !== E_SHIFT) begin
      errors++;
      $display("FAIL shift_entry obs=%b exp=%b", obs, E_SHIFT);
    end
    for (int n = 1; n <= NB; n++) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        cyc();
        checks++;
        if (obs !== E_SHIFT) begin
          errors++;
          $display("FAIL shift_gap n=%0d obs=%b exp=%b", n, obs, E_SHIFT);
        end
      end
      falling_edge_found = 1'b1;
      abort = (kill_kind == 1 && n == kill_at);
      cyc();
      falling_edge_found = 1'b0;
      abort = 1'b0;
      if (kill_kind == 1 && n == kill_at) begin
        checks++;
        if (obs !== E_IDLE) begin
          errors++;
          $display("FAIL abort n=%0d obs=%b exp=%b", n, obs, E_IDLE);
        end
        return;
      end
      if (kill_kind == 2 && n == kill_at) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_RST || tx_data !== '0) begin
          errors++;
          $display("FAIL reset_now obs=%b exp=%b tx_data=%h exp=0", obs, E_RST, tx_data);
        end
        cyc();
        checks++;
        if (obs !== E_RST) begin
          errors++;
          $display("FAIL reset_hold obs=%b exp=%b", obs, E_RST);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (obs !== E_IDLE) begin
          errors++;
          $display("FAIL reset_release obs=%b exp=%b", obs, E_IDLE);
        end
        return;
      end
      if (n == NB) begin
        checks++;
        if (obs !== E_DONE || tx_data !== data) begin
          errors++;
          $display("FAIL done obs=%b exp=%b tx_data=%h exp=%h", obs, E_DONE, tx_data, data);
        end
        cyc();
        checks++;
        if (obs !== E_IDLE) begin
          errors++;
          $display("FAIL after_done obs=%b exp=%b", obs, E_IDLE);
        end
      end else begin
        checks++;
        if (obs !== E_SHIFT) begin
          errors++;
          $display("FAIL shift_strobe n=%0d obs=%b exp=%b", n, obs, E_SHIFT);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    checks++;
    if (obs !== E_RST || tx_data !== '0) begin
      errors++;
      $display("FAIL reset obs=%b exp=%b tx_data=%h exp=0", obs, E_RST, tx_data);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("FAIL reset_exit obs=%b exp=%b", obs, E_IDLE);
    end
  endtask

  task automatic test_basic();
    run_block({16{8'hA5}}, 0, 0, 0, 0);
  endtask

  task automatic test_strobe_gaps();
    repeat (3) begin
      falling_edge_found = 1'b1;
      cyc();
      falling_edge_found = 1'b0;
      cyc();
      checks++;
      if (obs !== E_IDLE) begin
        errors++;
        $display("FAIL idle_strobe obs=%b exp=%b", obs, E_IDLE);
      end
    end
    run_block(rand_block(), 7, 7, 0, 0);
  endtask

  task automatic test_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("FAIL idle_abort obs=%b exp=%b", obs, E_IDLE);
    end
    run_block(rand_block(), 0, 2, 64, 1);
    run_block(128'h1, 0, 2, 0, 0);
  endtask

  task automatic test_collision();
    run_block(rand_block(), 0, 1, NB, 1);
  endtask

  task automatic test_reset_mid();
    run_block(rand_block(), 0, 1, 100, 2);
    run_block(rand_block(), 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      if ($urandom_range(0, 2) == 0)
        run_block(rand_block(), 0, 3, int'($urandom_range(1, NB)), 1);
      else
        run_block(rand_block(), 0, 3, 0, 0);
      repeat ($urandom_range(0, 3)) cyc();
    end
  endtask

  task automatic test_prefetch();
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    a = rand_block();
    b = 128'hDEAD;
    in_valid = 1'b1;
    in_data  = a;
    cyc();
    in_valid = 1'b0;
    cyc();
    in_valid = 1'b1;
    in_data  = b;
    checks++;
    if (in_ready !== PF) begin
      errors++;
      $display("FAIL shift_ready in_ready=%b exp=%b", in_ready, PF);
    end
    for (int n = 1; n <= NB; n++) begin
      falling_edge_found = 1'b1;
      cyc();
      checks++;
      if (obs !== ((n == NB) ? E_DONE : E_FULL)) begin
        errors++;
        $display("FAIL pf_shift n=%0d obs=%b exp=%b", n, obs, (n == NB) ? E_DONE : E_FULL);
      end
    end
    falling_edge_found = 1'b0;
    in_valid = 1'b0;
    cyc();
`ifdef TX_BLOCK_CTRL_PREFETCH_EN
    checks++;
    if (obs !== E_LOAD || tx_data !== b) begin
      errors++;
      $display("FAIL pf_reload obs=%b exp=%b tx_data=%h exp=%h", obs, E_LOAD, tx_data, b);
    end
    cyc();
    for (int n = 1; n <= NB; n++) begin
      falling_edge_found = 1'b1;
      cyc();
    end
    falling_edge_found = 1'b0;
    checks++;
    if (obs !== E_DONE || tx_data !== b) begin
      errors++;
      $display("FAIL pf_done obs=%b exp=%b tx_data=%h exp=%h", obs, E_DONE, tx_data, b);
    end
    cyc();
`endif
    checks++;
    if (obs !== E_IDLE || tx_data !== (PF ? b : a)) begin
      errors++;
      $display("FAIL pf_idle obs=%b exp=%b tx_data=%h exp=%h", obs, E_IDLE, tx_data, PF ? b : a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe_gaps();
    test_abort();
    test_collision();
    test_reset_mid();
    test_random();
    test_prefetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
